// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR front-end emulator: FSM states,
// default geometry, and the dither LFSR polynomial.
package sar_pkg;

  typedef enum logic {
    SAMPLE  = 1'b0,
    CONVERT = 1'b1
  } state_t;

  localparam int SAR_WIDTH   = 4;
  localparam int SAR_TIMEOUT = 8;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8 + x^6 + x^5 + x^4 + 1 maps to state bits 7, 5, 4, 3
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic lfsr_fb(input logic [7:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/sar_lfsr8.sv
// 8-bit Fibonacci LFSR, advances every clock, returns to the seed on reset.
module sar_lfsr8
  import sar_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] o_state
);

  logic [7:0] r_lfsr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[6:0], lfsr_fb(r_lfsr)};
    end
  end

  assign o_state = r_lfsr;

endmodule

// File: rtl/sar_afe_emu.sv
// SAR ADC analog front-end emulator: sample/hold, comparator, result capture and stats.
// Optional comparator dither is enabled by defining SAR_AFE_DITHER_EN.
module sar_afe_emu
  import sar_pkg::*;
#(
  parameter int WIDTH   = SAR_WIDTH,
  parameter int TIMEOUT = SAR_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] vin,
  input  logic [WIDTH-1:0] dac_code,
  input  logic             conv_done,
  output logic             d,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             match,
  output logic             timeout,
  output logic [7:0]       conv_count,
  output logic [7:0]       err_count
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] TO_MAX  = 8'(TIMEOUT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_hold;
  logic [7:0]       r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_result_valid;
  logic             r_match;
  logic             r_timeout;
  logic [7:0]       r_conv_count;
  logic [7:0]       r_err_count;

  logic             w_load;
  logic             w_capture;
  logic             w_expire;
  logic             w_eq;
  logic             w_err_inc;
  logic [WIDTH-1:0] w_hold_eff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= SAMPLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // conv_done takes priority over the watchdog when both land in one cycle
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    w_expire    = 1'b0;
    case (r_state)
      SAMPLE: begin
        w_load      = 1'b1;
        w_state_nxt = CONVERT;
      end
      CONVERT: begin
        if (conv_done) begin
          w_capture = 1'b1;
          w_load    = 1'b1;
        end else if (r_cnt == TO_LAST) begin
          w_expire    = 1'b1;
          w_state_nxt = SAMPLE;
        end
      end
      default: w_state_nxt = SAMPLE;
    endcase
  end

  assign w_eq      = (dac_code == r_hold);
  assign w_err_inc = (w_capture && !w_eq) || w_expire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold         <= '0;
      r_cnt          <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_match        <= 1'b0;
      r_timeout      <= 1'b0;
      r_conv_count   <= '0;
      r_err_count    <= '0;
    end else begin
      r_result_valid <= w_capture;
      r_timeout      <= w_expire;
      if (w_load) begin
        r_hold <= vin;
        r_cnt  <= '0;
      end else if (r_cnt != TO_MAX) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_capture) begin
        r_result     <= dac_code;
        r_match      <= w_eq;
        r_conv_count <= r_conv_count + 8'd1;
      end
      if (w_err_inc && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

`ifdef SAR_AFE_DITHER_EN
  logic [7:0]     w_lfsr;
  logic [WIDTH:0] w_hold_sum;

  sar_lfsr8 u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .o_state (w_lfsr)
  );

  // Saturate so a full-scale sample never wraps to zero at the comparator
  assign w_hold_sum = {1'b0, r_hold} + {{WIDTH{1'b0}}, w_lfsr[0]};
  assign w_hold_eff = w_hold_sum[WIDTH] ? {WIDTH{1'b1}} : w_hold_sum[WIDTH-1:0];
`else
  assign w_hold_eff = r_hold;
`endif

  assign d            = (w_hold_eff >= dac_code);
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign match        = r_match;
  assign timeout      = r_timeout;
  assign conv_count   = r_conv_count;
  assign err_count    = r_err_count;

endmodule

// File: tb/tb_sar_afe_emu.sv
// Bench for sar_afe_emu: behavioural SAR controller, vector table and result scoreboard.
module tb_sar_afe_emu;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] vin = '0;
  logic [W-1:0] dac_code = '0;
  logic         conv_done = 1'b0;
  logic         d;
  logic [W-1:0] result;
  logic         result_valid;
  logic         match;
  logic         timeout;
  logic [7:0]   conv_count;
  logic [7:0]   err_count;

  int n_pass = 0;
  int n_total = 0;
  int n_timeouts = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         mt;
  } exp_t;

  typedef struct {
    logic [W-1:0] vin;
    logic [W-1:0] exp_res;
    logic         exp_match;
  } vec_t;

  exp_t sb_q[$];
  vec_t sweep[16];

  always #5 clk = ~clk;

  sar_afe_emu #(.WIDTH(W), .TIMEOUT(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .vin          (vin),
    .dac_code     (dac_code),
    .conv_done    (conv_done),
    .d            (d),
    .result       (result),
    .result_valid (result_valid),
    .match        (match),
    .timeout      (timeout),
    .conv_count   (conv_count),
    .err_count    (err_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Release lands between edges so the next posedge is the first sampling edge
  task automatic do_reset(input logic [W-1:0] v);
    @(negedge clk);
    reset = 1'b1;
    conv_done = 1'b0;
    dac_code = '0;
    vin = v;
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Successive approximation driven by d; entered just after the hold-load edge
  task automatic run_conv(input logic [W-1:0] exp_res, input logic exp_mt,
                          input logic [W-1:0] next_v, output logic [W-1:0] dseq);
    logic [W-1:0] code;
    logic [W-1:0] trial;
    code = '0;
    dseq = '0;
    for (int b = W - 1; b >= 0; b--) begin
      trial = code;
      trial[b] = 1'b1;
      dac_code = trial;
      @(negedge clk);
      dseq[b] = d;
      if (d) code = trial;
      tick();
    end
    dac_code = code;
    conv_done = 1'b1;
    vin = next_v;
    sb_q.push_back('{exp_res, exp_mt});
    tick();
    conv_done = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && timeout) n_timeouts++;
    if (!reset && result_valid) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_result", 32'(result), 32'(e.res));
        chk("sb_match", 32'(match), 32'(e.mt));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [W-1:0] ds;
    logic [W-1:0] nv;

    for (int i = 0; i < 16; i++) sweep[i] = '{4'(i), 4'(i), 1'b1};

    // Reset values and comparator against hold=0
    @(negedge clk);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_conv_count", 32'(conv_count), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    dac_code = 4'd0; #1;
    chk("rst_d_code0", 32'(d), 32'd1);
    dac_code = 4'd1; #1;
    chk("rst_d_code1", 32'(d), 32'd0);
    dac_code = 4'd15; #1;
    chk("rst_d_code15", 32'(d), 32'd0);

    // Alignment after reset release with vin held at 1011
    vin = 4'b1011;
    dac_code = '0;
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("align_rv_before", 32'(result_valid), 32'd0);
    run_conv(4'b1011, 1'b1, 4'b1011, ds);
    chk("align_dseq", 32'(ds), 32'b1011);
    chk("align_rv_cycle6", 32'(result_valid), 32'd1);
    chk("align_result", 32'(result), 32'b1011);
    tick();
    chk("align_rv_one_pulse", 32'(result_valid), 32'd0);

    // Loopback sweep 0..15, one value per conversion
    do_reset(sweep[0].vin);
    tick();
    for (int i = 0; i < 16; i++) begin
      nv = (i < 15) ? sweep[i + 1].vin : 4'd0;
      run_conv(sweep[i].exp_res, sweep[i].exp_match, nv, ds);
      chk("sweep_result", 32'(result), 32'(sweep[i].exp_res));
      chk("sweep_dseq", 32'(ds), 32'(sweep[i].exp_res));
    end
    chk("sweep_conv_count", 32'(conv_count), 32'd16);
    chk("sweep_err_count", 32'(err_count), 32'd0);
    chk("sweep_no_timeout", 32'(n_timeouts), 32'd0);

    // Asynchronous reset in the middle of a conversion
    dac_code = 4'd8;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_conv_count", 32'(conv_count), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_d", 32'(d), 32'd0);

    // Forced mismatch against hold=9, plus comparator boundary
    do_reset(4'd9);
    tick();
    dac_code = 4'd9; #1;
    chk("mm_d_equal", 32'(d), 32'd1);
    dac_code = 4'd10; #1;
    chk("mm_d_above", 32'(d), 32'd0);
    dac_code = 4'd5;
    conv_done = 1'b1;
    sb_q.push_back('{4'd5, 1'b0});
    tick();
    conv_done = 1'b0;
    chk("mm_match", 32'(match), 32'd0);
    chk("mm_err_count", 32'(err_count), 32'd1);
    chk("mm_conv_count", 32'(conv_count), 32'd1);
    chk("mm_result_valid", 32'(result_valid), 32'd1);

    // Watchdog: eight CONVERT cycles without conv_done
    do_reset(4'd6);
    n_timeouts = 0;
    tick();
    vin = 4'd12;
    dac_code = 4'd12; #1;
    chk("wd_d_old_hold", 32'(d), 32'd0);
    repeat (7) tick();
    chk("wd_no_early_timeout", 32'(timeout), 32'd0);
    tick();
    chk("wd_timeout_pulse", 32'(timeout), 32'd1);
    chk("wd_err_count", 32'(err_count), 32'd1);
    chk("wd_conv_count", 32'(conv_count), 32'd0);
    tick();
    chk("wd_timeout_cleared", 32'(timeout), 32'd0);
    dac_code = 4'd12; #1;
    chk("wd_hold_reload_eq", 32'(d), 32'd1);
    dac_code = 4'd13; #1;
    chk("wd_hold_reload_above", 32'(d), 32'd0);
    chk("wd_timeout_once", 32'(n_timeouts), 32'd1);

    // conv_done on the eighth CONVERT cycle beats the watchdog
    repeat (7) tick();
    dac_code = 4'd12;
    conv_done = 1'b1;
    sb_q.push_back('{4'd12, 1'b1});
    tick();
    conv_done = 1'b0;
    chk("wd8_no_timeout", 32'(timeout), 32'd0);
    chk("wd8_result_valid", 32'(result_valid), 32'd1);
    chk("wd8_err_count", 32'(err_count), 32'd1);
    chk("wd8_conv_count", 32'(conv_count), 32'd1);
    tick();
    chk("wd8_no_late_timeout", 32'(timeout), 32'd0);
    chk("wd8_timeout_count", 32'(n_timeouts), 32'd1);

    // 300 back-to-back mismatches: err_count saturates, conv_count wraps
    do_reset(4'd9);
    tick();
    dac_code = 4'd5;
    conv_done = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      sb_q.push_back('{4'd5, 1'b0});
      tick();
      if (i == 255) begin
        chk("sat_err_255", 32'(err_count), 32'd255);
        chk("sat_conv_255", 32'(conv_count), 32'd255);
      end
      if (i == 256) begin
        chk("sat_err_hold", 32'(err_count), 32'd255);
        chk("sat_conv_wrap", 32'(conv_count), 32'd0);
      end
    end
    conv_done = 1'b0;
    chk("sat_err_final", 32'(err_count), 32'd255);
    chk("sat_conv_final", 32'(conv_count), 32'd44);

    tick();
    tick();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
